// File: rtl/cv32e40p_pkg.sv
// Shared types for the prefetch sequencer: FSM state encoding and address alignment helper.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        BRANCH_WAIT = 2'd1,
        ERR_HALT    = 2'd2
    } prefetch_seq_state_e;

    function automatic logic [31:0] align_addr(input logic [31:0] addr, input int unsigned bytes);
        return addr & ~(32'(bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/cv32e40p_prefetch_flush_cnt.sv
// Counts bus responses still to be discarded after a redirect; responses are only
// forwarded once this counter has drained to zero.
module cv32e40p_prefetch_flush_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] outstanding_i,
    input  logic             resp_valid_i,
    output logic             flushing_o
);

    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A response arriving in the redirect cycle already belongs to the old stream.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (load_i) begin
            flush_cnt_d = outstanding_i;
            if (resp_valid_i && outstanding_i != '0) begin
                flush_cnt_d = outstanding_i - CNT_W'(1);
            end
        end else if (resp_valid_i && flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flushing_o = (flush_cnt_q != '0);

endmodule

// File: rtl/cv32e40p_prefetch_sequencer.sv
// Instruction prefetch sequencer: issues fetch addresses, tracks outstanding bus traffic and
// steers responses to fetch or FIFO. Hardware-loop redirects enabled by CV32E40P_PREFETCH_HWLP_EN.
module cv32e40p_prefetch_sequencer
    import cv32e40p_pkg::*;
#(
    parameter  int unsigned DEPTH           = 4,
    parameter  int unsigned MAX_OUTSTANDING = 2,
    parameter  int unsigned FETCH_BYTES     = 4,
    localparam int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    input  logic             hwlp_jump_i,
    input  logic [31:0]      hwlp_target_i,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    output logic [31:0]      trans_addr_o,
    input  logic             resp_valid_i,
    input  logic             resp_err_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic             fifo_push_o,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             busy_o
);

    localparam logic [CNT_W:0]   DEPTH_L   = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_L = CNT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      FB_L      = 32'(FETCH_BYTES);

    prefetch_seq_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic                hwlp_jump;
    logic                handshake;
    logic                flushing;
    logic                fifo_nonempty;
    logic                resp_fwd_ok;
    logic [CNT_W-1:0]    cnt_m;

`ifdef CV32E40P_PREFETCH_HWLP_EN
    assign hwlp_jump = hwlp_jump_i;
`else
    logic unused_hwlp_jump;
    assign unused_hwlp_jump = hwlp_jump_i;
    assign hwlp_jump        = 1'b0;
`endif

    // A redirect discards the FIFO contents, so their occupancy no longer limits issue.
    assign cnt_m         = (branch_i || hwlp_jump) ? '0 : fifo_cnt_i;
    assign fifo_nonempty = (fifo_cnt_i != '0);

    assign trans_valid_o = rst_n && req_i
                         && !(state_q == ERR_HALT && !branch_i)
                         && (({1'b0, cnt_m} + {1'b0, cnt_q}) < DEPTH_L)
                         && (cnt_q < MAX_OUT_L);
    assign handshake     = trans_valid_o && trans_ready_i;

    always_comb begin
        if (branch_i) begin
            trans_addr_o = align_addr(branch_addr_i, FETCH_BYTES);
        end else if (hwlp_jump) begin
            trans_addr_o = align_addr(hwlp_target_i, FETCH_BYTES);
        end else if (state_q == BRANCH_WAIT) begin
            trans_addr_o = addr_q;
        end else begin
            trans_addr_o = align_addr(addr_q, FETCH_BYTES) + FB_L;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (branch_i || hwlp_jump || handshake) begin
            addr_d = trans_addr_o;
        end
    end

    // A branch overrides everything, including an error arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        if (branch_i) begin
            state_d = handshake ? IDLE : BRANCH_WAIT;
        end else if (resp_valid_i && resp_err_i && !flushing) begin
            state_d = ERR_HALT;
        end else begin
            case (state_q)
                IDLE:        if (hwlp_jump && !handshake) state_d = BRANCH_WAIT;
                BRANCH_WAIT: if (handshake) state_d = IDLE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (handshake && !resp_valid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!handshake && resp_valid_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    cv32e40p_prefetch_flush_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (branch_i || hwlp_jump),
        .outstanding_i (cnt_q),
        .resp_valid_i  (resp_valid_i),
        .flushing_o    (flushing)
    );

    // Responses bypass the FIFO when it is empty and fetch can take them directly.
    assign resp_fwd_ok   = !branch_i && !flushing;
    assign fetch_valid_o = rst_n && (fifo_nonempty || resp_valid_i) && resp_fwd_ok;
    assign fifo_push_o   = rst_n && resp_valid_i && (fifo_nonempty || !fetch_ready_i) && resp_fwd_ok;
    assign fifo_pop_o    = rst_n && fifo_nonempty && fetch_ready_i;
    assign fifo_flush_o  = rst_n && branch_i;
    assign busy_o        = (cnt_q != '0) || trans_valid_o;

endmodule

// File: tb/tb_cv32e40p_prefetch_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural model of the fetch stream.
module tb_cv32e40p_prefetch_sequencer;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam int FB    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqI = 1'b0, branchI = 1'b0, hwlpI = 1'b0, readyI = 1'b0;
    logic        respI = 1'b0, errI = 1'b0, fetchReadyI = 1'b0;
    logic [31:0] branchAddrI = '0, hwlpTargetI = '0;
    logic [2:0]  fifoCntI = '0;
    logic        transValid, fetchValid, fifoPush, fifoPop, fifoFlush, busy;
    logic [31:0] transAddr;
    logic        transValid8, fetchValid8, fifoPush8, fifoPop8, fifoFlush8, busy8;
    logic [31:0] transAddr8;

    int assertCount = 0;
    int failCount   = 0;
    bit modelOn     = 0;

    bit          mHalted, mReplay;
    logic [31:0] mNextPc;
    int          mOut, mDrop;

    always #5 clk = ~clk;

    cv32e40p_prefetch_sequencer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .FETCH_BYTES(FB)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(reqI), .branch_i(branchI), .branch_addr_i(branchAddrI),
        .hwlp_jump_i(hwlpI), .hwlp_target_i(hwlpTargetI), .trans_valid_o(transValid),
        .trans_ready_i(readyI), .trans_addr_o(transAddr), .resp_valid_i(respI), .resp_err_i(errI),
        .fetch_ready_i(fetchReadyI), .fetch_valid_o(fetchValid), .fifo_push_o(fifoPush),
        .fifo_pop_o(fifoPop), .fifo_flush_o(fifoFlush), .fifo_cnt_i(fifoCntI), .busy_o(busy)
    );

    cv32e40p_prefetch_sequencer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .FETCH_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_i(reqI), .branch_i(branchI), .branch_addr_i(branchAddrI),
        .hwlp_jump_i(hwlpI), .hwlp_target_i(hwlpTargetI), .trans_valid_o(transValid8),
        .trans_ready_i(readyI), .trans_addr_o(transAddr8), .resp_valid_i(respI), .resp_err_i(errI),
        .fetch_ready_i(fetchReadyI), .fetch_valid_o(fetchValid8), .fifo_push_o(fifoPush8),
        .fifo_pop_o(fifoPop8), .fifo_flush_o(fifoFlush8), .fifo_cnt_i(fifoCntI), .busy_o(busy8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit req, input bit br, input logic [31:0] bAddr,
                                 input bit ready, input bit resp, input bit err,
                                 input logic [2:0] fcnt, input bit fready);
        @(posedge clk);
        #1;
        reqI = req; branchI = br; branchAddrI = bAddr; readyI = ready;
        respI = resp; errI = err; fifoCntI = fcnt; fetchReadyI = fready;
        hwlpI = 1'b0; hwlpTargetI = '0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        reqI = 0; branchI = 0; branchAddrI = '0; hwlpI = 0; hwlpTargetI = '0;
        readyI = 0; respI = 0; errI = 0; fifoCntI = '0; fetchReadyI = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Model of the fetch stream: next address to issue, in-flight count, responses to drop.
    always @(negedge clk) begin : modelBlk
        bit          eValid, eHs, eFv, ePush, ePop, eBusy, errHit;
        logic [31:0] eAddr;
        int          occ;
        if (!rst_n) begin
            mHalted = 0; mReplay = 0; mNextPc = 32'(FB); mOut = 0; mDrop = 0;
            if (modelOn) begin
                checkOutput("rst_trans_valid", {31'b0, transValid}, 32'd0);
                checkOutput("rst_trans_addr", transAddr, 32'(FB));
                checkOutput("rst_fetch_valid", {31'b0, fetchValid}, 32'd0);
                checkOutput("rst_busy", {31'b0, busy}, 32'd0);
                checkOutput("rst_flush", {31'b0, fifoFlush}, 32'd0);
            end
        end else if (modelOn) begin
            occ    = branchI ? 0 : int'(fifoCntI);
            eValid = reqI && !(mHalted && !branchI) && (occ + mOut < DEPTH) && (mOut < MAXO);
            eAddr  = branchI ? (branchAddrI & ~32'(FB - 1)) : mNextPc;
            eHs    = eValid && readyI;
            eFv    = (fifoCntI != 0 || respI) && !branchI && mDrop == 0;
            ePush  = respI && (fifoCntI != 0 || !fetchReadyI) && !branchI && mDrop == 0;
            ePop   = (fifoCntI != 0) && fetchReadyI;
            eBusy  = (mOut != 0) || eValid;
            checkOutput("trans_valid", {31'b0, transValid}, {31'b0, eValid});
            checkOutput("trans_addr", transAddr, eAddr);
            checkOutput("fetch_valid", {31'b0, fetchValid}, {31'b0, eFv});
            checkOutput("fifo_push", {31'b0, fifoPush}, {31'b0, ePush});
            checkOutput("fifo_pop", {31'b0, fifoPop}, {31'b0, ePop});
            checkOutput("fifo_flush", {31'b0, fifoFlush}, {31'b0, branchI});
            checkOutput("busy", {31'b0, busy}, {31'b0, eBusy});

            errHit = respI && errI && mDrop == 0 && !branchI;
            if (branchI) begin
                mNextPc = eHs ? eAddr + 32'(FB) : eAddr;
                mReplay = !eHs;
                mHalted = 0;
                mDrop   = mOut - ((respI && mOut > 0) ? 1 : 0);
            end else begin
                if (respI && mDrop > 0) mDrop--;
                if (eHs) begin
                    mNextPc = eAddr + 32'(FB);
                    mReplay = 0;
                end
                if (errHit) begin
                    if (mReplay) mNextPc = mNextPc + 32'(FB);
                    mReplay = 0;
                    mHalted = 1;
                end
            end
            mOut = mOut + (eHs ? 1 : 0) - (respI ? 1 : 0);
        end
    end

    initial begin
        doReset();
        modelOn = 1;

        // Sequential issue stops at the outstanding cap.
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("seq_valid0", {31'b0, transValid}, 32'd1);
        checkOutput("seq_addr0", transAddr, 32'h4);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("seq_addr1", transAddr, 32'h8);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("seq_capped", {31'b0, transValid}, 32'd0);
        checkOutput("seq_busy", {31'b0, busy}, 32'd1);

        // Branch with two in flight: two responses dropped, third delivered.
        applyStimulus(1, 1, 32'h1006, 1, 0, 0, 0, 1);
        #2 checkOutput("br_addr", transAddr, 32'h1004);
        checkOutput("br_flush", {31'b0, fifoFlush}, 32'd1);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 1);
        #2 checkOutput("drop1", {31'b0, fetchValid}, 32'd0);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 1);
        #2 checkOutput("drop2", {31'b0, fetchValid}, 32'd0);
        checkOutput("br_replay", transAddr, 32'h1004);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 1);
        #2 checkOutput("deliver3", {31'b0, fetchValid}, 32'd1);
        checkOutput("bypass_nopush", {31'b0, fifoPush}, 32'd0);
        checkOutput("after_replay", transAddr, 32'h1008);

        // Branch stalled by the bus holds its address until a second branch.
        doReset();
        applyStimulus(1, 1, 32'h300, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
            #2 checkOutput("bw_hold", transAddr, 32'h300);
        end
        applyStimulus(1, 1, 32'h2000, 1, 0, 0, 0, 1);
        #2 checkOutput("bw_rebranch", transAddr, 32'h2000);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("bw_next", transAddr, 32'h2004);

        // Bus error halts issue until a branch.
        doReset();
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
            #2 checkOutput("halt_novalid", {31'b0, transValid}, 32'd0);
        end
        applyStimulus(1, 1, 32'h40, 1, 0, 0, 0, 1);
        #2 checkOutput("halt_branch_valid", {31'b0, transValid}, 32'd1);
        checkOutput("halt_branch_addr", transAddr, 32'h40);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("halt_resume", transAddr, 32'h44);

        // 8-byte fetch wraps at the top of the address space.
        doReset();
        applyStimulus(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 1);
        #2 checkOutput("fb8_addr0", transAddr8, 32'hFFFF_FFF8);
        checkOutput("fb8_valid0", {31'b0, transValid8}, 32'd1);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #2 checkOutput("fb8_wrap", transAddr8, 32'h0);
        checkOutput("fb4_wrap", transAddr, 32'h0);

        // Asynchronous reset with traffic in flight.
        doReset();
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_valid", {31'b0, transValid}, 32'd0);
        checkOutput("async_addr", transAddr, 32'h4);
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            reqI        = ($urandom_range(9) != 0);
            branchI     = ($urandom_range(11) == 0);
            branchAddrI = $urandom;
            hwlpI       = ($urandom_range(7) == 0);
            hwlpTargetI = $urandom;
            readyI      = ($urandom_range(9) < 7);
            respI       = (mOut > 0) && ($urandom_range(1) == 1);
            errI        = respI && ($urandom_range(19) == 0);
            fifoCntI    = 3'($urandom_range(DEPTH));
            fetchReadyI = $urandom_range(1) == 1;
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cv32e40p_prefetch_sequencer.md
CV32E40P_PREFETCH_SEQUENCER -- requirements
Module: cv32e40p_prefetch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 4, prefetch FIFO depth in entries, power of 2, legal range 2..16.
REQ-002 SHALL have parameter MAX_OUTSTANDING, 2, cap on in-flight bus transactions, legal range 1..DEPTH.
REQ-003 SHALL have parameter FETCH_BYTES, 4, bytes per transaction, legal values 4 or 8; CNT_W = $clog2(DEPTH)+1 is derived and not overridable.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  in  1  fetch stage requests instructions.
REQ-007 SHALL have port branch_i / branch_addr_i  in  1/32  taken branch and its target.
REQ-008 SHALL have port hwlp_jump_i / hwlp_target_i  in  1/32  hardware-loop jump and its target.
REQ-009 SHALL have port trans_valid_o / trans_ready_i / trans_addr_o  out/in/out  1/1/32  transaction request channel.
REQ-010 SHALL have port resp_valid_i / resp_err_i  in  1/1  response valid and bus error flag.
REQ-011 SHALL have port fetch_ready_i / fetch_valid_o  in/out  1/1  fetch handshake.
REQ-012 SHALL have port fifo_push_o / fifo_pop_o / fifo_flush_o  out  1 each  FIFO controls.
REQ-013 SHALL have port fifo_cnt_i  in  CNT_W  FIFO occupancy, where fifo_cnt_i==0 means empty; and port busy_o  out  1  outstanding or requested traffic.

Function
REQ-014 SHALL implement states IDLE, BRANCH_WAIT and ERR_HALT.
REQ-015 SHALL drive trans_valid_o = req_i && !(state==ERR_HALT && !branch_i) && (cnt_m + cnt_q < DEPTH) && (cnt_q < MAX_OUTSTANDING), where cnt_m = 0 when branch_i or hwlp_jump_i is high, else fifo_cnt_i.
REQ-016 SHALL select trans_addr_o by priority: branch_i gives branch_addr_i aligned down to FETCH_BYTES; else hwlp_jump_i gives hwlp_target_i aligned; else BRANCH_WAIT replays addr_q; else addr_q aligned + FETCH_BYTES, wrapping modulo 2^32.
REQ-017 SHALL load addr_q with trans_addr_o on branch_i, on hwlp_jump_i, or on handshake (trans_valid_o && trans_ready_i).
REQ-018 SHALL move IDLE to BRANCH_WAIT when branch_i or hwlp_jump_i is high without a handshake in the same cycle, and BRANCH_WAIT to IDLE on handshake.
REQ-019 SHALL move to ERR_HALT on an unflushed response with resp_err_i=1; ERR_HALT SHALL exit only on branch_i, to IDLE on handshake, else to BRANCH_WAIT.
REQ-020 SHALL keep cnt_q (width CNT_W) as +1 on handshake, -1 on resp_valid_i, unchanged when both or neither occur.
REQ-021 SHALL, on branch_i, set flush_cnt to cnt_q, minus 1 if resp_valid_i && cnt_q>0; otherwise decrement flush_cnt on resp_valid_i when it is >0.
REQ-022 SHALL drive fetch_valid_o = (fifo_cnt_i!=0 || resp_valid_i) && !branch_i && flush_cnt==0.
REQ-023 SHALL drive fifo_push_o = resp_valid_i && (fifo_cnt_i!=0 || !fetch_ready_i) && !branch_i && flush_cnt==0, i.e. bypass to fetch when FIFO is empty and ready.
REQ-024 SHALL drive fifo_pop_o = (fifo_cnt_i!=0) && fetch_ready_i, and fifo_flush_o = branch_i.
REQ-025 SHALL drive busy_o = (cnt_q!=0) || trans_valid_o.
REQ-026 SHALL cope with branch_i and hwlp_jump_i high in the same cycle, with branch_i winning and no flush applied for the HW loop.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state=IDLE, cnt_q=0, flush_cnt=0 and addr_q=0.
REQ-028 SHALL hold all outputs at 0 during reset; trans_addr_o SHALL equal FETCH_BYTES.

Configuration
REQ-029 SHALL support macro CV32E40P_PREFETCH_HWLP_EN: when defined, hwlp_jump_i acts as specified above and additionally loads flush_cnt like branch_i, except that responses already pushed before the jump are kept.
REQ-030 SHALL, without CV32E40P_PREFETCH_HWLP_EN, keep the hwlp ports present but ignore them internally, treating hwlp_jump_i as 0.

Structure
REQ-031 SHALL use prefetch_seq_state_e {IDLE, BRANCH_WAIT, ERR_HALT} defined in cv32e40p_pkg.
REQ-032 SHALL instantiate one sub-module, cv32e40p_prefetch_flush_cnt, which holds the flush counter.

Verification
REQ-033 SHALL cover: DEPTH=4, MAX_OUTSTANDING=2, trans_ready_i=1, no responses -> exactly 2 handshakes at 0x4 and 0x8, then trans_valid_o=0.
REQ-034 SHALL cover: branch_i to 0x1006 while cnt_q=2 -> trans_addr_o=0x1004, the next 2 responses are dropped (fetch_valid_o=0), and the 3rd is delivered.
REQ-035 SHALL cover: branch with trans_ready_i=0 for 3 cycles -> state BRANCH_WAIT with the address held, followed by a second branch to 0x2000 -> 0x2000 is issued.
REQ-036 SHALL cover: resp_err_i=1 -> ERR_HALT and trans_valid_o=0 despite req_i=1; after a branch to 0x40, issue resumes.
REQ-037 SHALL cover: FETCH_BYTES=8 with a branch to 0xFFFFFFFC -> issues 0xFFFFFFF8 then 0x00000000.
REQ-038 SHALL cover: rst_n asserted with cnt_q=2 -> all counters reach 0 immediately and busy_o=0.
